edge_event_detector: RTL and testbench

- Multi-channel, parametrised edge/event detector; successor of the single-bit posedge/negedge detector used in the FFT control path.
- Per channel: configurable synchroniser depth, debounce filter, run-time edge mode (off/rise/fall/both).
- Outputs per channel: a one-cycle event pulse and a sticky pending bit with software-style clear.
- Sits between asynchronous or noisy control inputs (start, frame, mode strobes) and the FFT sequencer.

---
 rtl/edge_event_pkg.sv | 33 +++
 rtl/edge_event_if.sv | 35 +++
 rtl/edge_event_channel.sv | 75 +++++++
 rtl/edge_event_detector.sv | 85 ++++++++
 tb/tb_edge_event_detector.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/edge_event_pkg.sv
// Shared types and sizing helpers for the multi-channel edge/event detector.
// The optional interrupt output is controlled by the EDGE_EVENT_IRQ_EN macro.
package edge_event_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Filter length: a zero FILTER_CYCLES behaves as a single-cycle filter.
  function automatic int filt_len(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic logic edge_hit(input edge_mode_e mode, input logic rising);
    logic hit;
    case (mode)
      EDGE_RISE: hit = rising;
      EDGE_FALL: hit = ~rising;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_event_if.sv
// Channel-vector signal bundle between the control inputs and the detector.
// EDGE_EVENT_IRQ_EN adds the interrupt mask input and the interrupt output.
interface edge_event_if #(parameter int NUM_CH = 8);

  logic [NUM_CH-1:0]   i_signal;
  logic [2*NUM_CH-1:0] i_mode;
  logic [NUM_CH-1:0]   i_clr;
  logic [NUM_CH-1:0]   o_level;
  logic [NUM_CH-1:0]   o_pulse;
  logic [NUM_CH-1:0]   o_pending;
  logic                o_armed;
`ifdef EDGE_EVENT_IRQ_EN
  logic [NUM_CH-1:0]   i_irq_mask;
  logic                o_irq;
`endif

  modport master (
    output i_signal, i_mode, i_clr,
    input  o_level, o_pulse, o_pending, o_armed
`ifdef EDGE_EVENT_IRQ_EN
    , output i_irq_mask
    , input  o_irq
`endif
  );

  modport slave (
    input  i_signal, i_mode, i_clr,
    output o_level, o_pulse, o_pending, o_armed
`ifdef EDGE_EVENT_IRQ_EN
    , input  i_irq_mask
    , output o_irq
`endif
  );

endinterface

// File: rtl/edge_event_channel.sv
// One detector channel: synchroniser chain, glitch filter and edge classification.
// The next-cycle pulse is exported so the top can set pending on the same edge.
module edge_event_channel
  import edge_event_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_signal,
  input  edge_mode_e i_mode,
  input  logic       i_armed,
  output logic       o_level,
  output logic       o_pulse,
  output logic       o_pulse_next
);

  localparam int FLT_N = filt_len(FILTER_CYCLES);
  localparam int CW    = cnt_width(FLT_N);
  localparam logic [CW-1:0] FLT_LAST = CW'(FLT_N - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   s_i;

  assign s_i = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = i_signal;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
  end

  // Before arming, level follows the synchroniser output it is about to see,
  // so an input already high at reset release never looks like an edge.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!i_armed) begin
      level_d = sync_d[SYNC_STAGES-1];
      cnt_d   = '0;
    end else if (s_i == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == FLT_LAST) begin
      level_d = s_i;
      cnt_d   = '0;
      pulse_d = edge_hit(i_mode, s_i);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_level      = level_q;
  assign o_pulse      = pulse_q;
  assign o_pulse_next = pulse_d;

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel edge/event detector top: arm counter, sticky pending flags,
// per-channel detectors; EDGE_EVENT_IRQ_EN adds a masked, registered interrupt.
module edge_event_detector
  import edge_event_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input logic          i_clk,
  input logic          i_rst,
  edge_event_if.slave  bus
);

  localparam int AW = cnt_width(SYNC_STAGES);
  localparam logic [AW-1:0] ARM_LAST = AW'(SYNC_STAGES - 1);

  logic [AW-1:0]     arm_cnt_q, arm_cnt_d;
  logic              armed_q, armed_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] level, pulse, pulse_next;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_event_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_signal     (bus.i_signal[g]),
      .i_mode       (edge_mode_e'(bus.i_mode[2*g +: 2])),
      .i_armed      (armed_q),
      .o_level      (level[g]),
      .o_pulse      (pulse[g]),
      .o_pulse_next (pulse_next[g])
    );
  end

  always_comb begin
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;
    if (!armed_q) begin
      if (arm_cnt_q == ARM_LAST) armed_d = 1'b1;
      else                       arm_cnt_d = arm_cnt_q + 1'b1;
    end
  end

  // Set beats clear when both land on the same edge.
  always_comb begin
    pending_d = pending_q;
    if (armed_q) pending_d = (pending_q & ~bus.i_clr) | pulse_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
      pending_q <= '0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
      pending_q <= pending_d;
    end
  end

  assign bus.o_level   = level;
  assign bus.o_pulse   = pulse;
  assign bus.o_pending = pending_q;
  assign bus.o_armed   = armed_q;

`ifdef EDGE_EVENT_IRQ_EN
  logic irq_q, irq_d;

  // Driven from the registered pending flags, so it trails the pending set by a cycle.
  always_comb irq_d = |(pending_q & bus.i_irq_mask);

  always_ff @(posedge i_clk) begin
    if (i_rst) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign bus.o_irq = irq_q;
`endif

endmodule

// File: tb/tb_edge_event_detector.sv
// Directed bench for edge_event_detector: unfiltered (a) and 3-cycle filtered (b)
// instances; interrupt checks only when EDGE_EVENT_IRQ_EN is defined.
module tb_edge_event_detector;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 i_clk = ~i_clk;

  edge_event_if #(.NUM_CH(4)) if_a ();
  edge_event_if #(.NUM_CH(4)) if_b ();

  edge_event_detector #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0)) u_dut_a (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (if_a)
  );

  edge_event_detector #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3)) u_dut_b (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (if_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst         = 1'b1;
    if_a.i_signal = 4'b0010;
    if_a.i_mode   = 8'hFF;
    if_a.i_clr    = 4'b0000;
    if_b.i_signal = 4'b0000;
    if_b.i_mode   = 8'hFF;
    if_b.i_clr    = 4'b0000;
`ifdef EDGE_EVENT_IRQ_EN
    if_a.i_irq_mask = 4'b0010;
    if_b.i_irq_mask = 4'b0000;
`endif
    tick(3);
    check("rst_level", if_a.o_level, 4'b0000);
    check("rst_pulse", if_a.o_pulse, 4'b0000);
    check("rst_pending", if_a.o_pending, 4'b0000);
    check("rst_armed", if_a.o_armed, 1'b0);

    // Release with ch1 already high: arms after two edges, no edge seen.
    i_rst = 1'b0;
    tick();
    check("arm_r1", if_a.o_armed, 1'b0);
    tick();
    check("arm_r2", if_a.o_armed, 1'b1);
    check("arm_level", if_a.o_level, 4'b0010);
    check("arm_b_armed", if_b.o_armed, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arm_no_pulse", if_a.o_pulse, 4'b0000);
      check("arm_no_pending", if_a.o_pending, 4'b0000);
    end

    // ch0 rise: captured at E0, visible at E0+2 only.
    if_a.i_signal = 4'b0011;
    tick();
    check("rise_e0_level", if_a.o_level, 4'b0010);
    tick();
    check("rise_e1_pulse", if_a.o_pulse, 4'b0000);
    tick();
    check("rise_e2_level", if_a.o_level, 4'b0011);
    check("rise_e2_pulse", if_a.o_pulse, 4'b0001);
    check("rise_e2_pending", if_a.o_pending, 4'b0001);
    tick();
    check("rise_e3_pulse", if_a.o_pulse, 4'b0000);
    check("rise_e3_pending", if_a.o_pending, 4'b0001);
    if_a.i_clr = 4'b0001;
    tick();
    check("clr_pending", if_a.o_pending, 4'b0000);
    if_a.i_clr = 4'b0000;

    // ch0 fall with clear on the same edge as the pulse: set wins.
    if_a.i_signal = 4'b0010;
    tick(2);
    if_a.i_clr = 4'b0001;
    tick();
    check("setclr_pulse", if_a.o_pulse, 4'b0001);
    check("setclr_pending", if_a.o_pending, 4'b0001);
    tick();
    check("clr_next_pending", if_a.o_pending, 4'b0000);
    if_a.i_clr = 4'b0000;

    // ch3 RISE, period-8 square wave, FALL selected while level is high.
    // Toggles land at edges 2r,6f,10r,14f,18r,22f; pulses expected at 2,10,14,22.
    if_a.i_mode = 8'b01_11_11_11;
    for (int c = 0; c < 26; c++) begin
      if_a.i_signal[3] = (c < 24) && (((c / 4) % 2) == 0);
      if (c == 12) if_a.i_mode = 8'b10_11_11_11;
      tick();
      check($sformatf("mode_c%0d", c), if_a.o_pulse[3],
            (c == 2 || c == 10 || c == 14 || c == 22) ? 1'b1 : 1'b0);
    end
    check("mode_pending3", if_a.o_pending, 4'b1000);

    // Filtered instance: 2-cycle glitch on ch2 suppressed.
    if_b.i_signal = 4'b0100;
    tick(2);
    if_b.i_signal = 4'b0000;
    for (int t = 0; t < 6; t++) begin
      tick();
      check("glitch_level", if_b.o_level, 4'b0000);
      check("glitch_pulse", if_b.o_pulse, 4'b0000);
    end

    // Stable high on ch2: single pulse at E0+4.
    if_b.i_signal = 4'b0100;
    for (int t = 0; t < 8; t++) begin
      tick();
      check($sformatf("filt_pulse_t%0d", t), if_b.o_pulse, (t == 4) ? 4'b0100 : 4'b0000);
      check($sformatf("filt_level_t%0d", t), if_b.o_level, (t >= 4) ? 4'b0100 : 4'b0000);
    end
    check("filt_pending", if_b.o_pending, 4'b0100);

    // Reset with a ch2 edge in flight: discarded, no pulse after re-arm.
    if_a.i_signal = 4'b0110;
    tick();
    i_rst = 1'b1;
    tick();
    check("midrst_pending", if_a.o_pending, 4'b0000);
    check("midrst_armed", if_a.o_armed, 1'b0);
    check("midrst_level", if_a.o_level, 4'b0000);
    i_rst = 1'b0;
    tick(2);
    check("rearm_armed", if_a.o_armed, 1'b1);
    check("rearm_level", if_a.o_level, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rearm_no_pulse", if_a.o_pulse, 4'b0000);
      check("rearm_no_pending", if_a.o_pending, 4'b0000);
    end

`ifdef EDGE_EVENT_IRQ_EN
    // Mask 0010: ch0 pulse must not raise irq, ch1 pulse raises it a cycle later.
    check("irq_idle", if_a.o_irq, 1'b0);
    if_a.i_signal = 4'b0111;
    tick(3);
    check("irq_ch0_pending", if_a.o_pending, 4'b0001);
    check("irq_ch0_irq", if_a.o_irq, 1'b0);
    tick();
    check("irq_ch0_irq_late", if_a.o_irq, 1'b0);
    if_a.i_signal = 4'b0101;
    tick(3);
    check("irq_ch1_pulse", if_a.o_pulse, 4'b0010);
    check("irq_ch1_pending", if_a.o_pending, 4'b0011);
    check("irq_ch1_same", if_a.o_irq, 1'b0);
    tick();
    check("irq_ch1_rise", if_a.o_irq, 1'b1);
    if_a.i_clr = 4'b0010;
    tick();
    if_a.i_clr = 4'b0000;
    check("irq_clr_pending", if_a.o_pending, 4'b0001);
    check("irq_clr_hold", if_a.o_irq, 1'b1);
    tick();
    check("irq_fall", if_a.o_irq, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
